// File: rtl/slave_port_ctrl_if.sv
// Bus bundle for slave_port_ctrl: the serial master-side handshake pair and the
// parallel memory-side strobes.
//   slave  modport : the port controller (drives slave_*, rd_bus and mem_* strobes)
//   master modport : the bus master / memory model (drives wr_bus, mode, ready/valid in)
interface slave_port_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
);
  // Serial write side
  logic                  mode;
  logic                  wr_bus;
  logic                  master_valid;
  logic                  slave_ready;
  // Serial read side
  logic                  rd_bus;
  logic                  slave_valid;
  logic                  master_ready;
  logic                  slave_split;
  // Memory side
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;

  modport slave (
    input  mode, wr_bus, master_valid, master_ready, mem_rdata, mem_rvalid,
    output slave_ready, rd_bus, slave_valid, slave_split,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output mode, wr_bus, master_valid, master_ready, mem_rdata, mem_rvalid,
    input  slave_ready, rd_bus, slave_valid, slave_split,
           mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/slave_port_ctrl.sv
// slave_port_ctrl: serial-bus slave port in front of a single-port memory.
// A transaction starts with mode + ADDR_WIDTH address bits (MSB first) on wr_bus;
// writes follow with DATA_WIDTH data bits and a one-cycle mem_we, reads issue a
// one-cycle mem_re, wait for mem_rvalid and return DATA_WIDTH bits on rd_bus.
// Ports:
//   clk, rstn : clock (rising edge) and asynchronous active-low reset
//   bus       : slave_port_ctrl_if.slave (serial handshakes + memory strobes)
// Build option:
//   SLAVE_SPLIT_EN : when defined, a read waiting SPLIT_TIMEOUT cycles raises
//                    slave_split and parks in SPLIT until the memory answers.
module slave_port_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SPLIT_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  slave_port_ctrl_if.slave     bus
);

  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned BC_W  = $clog2(MAX_W);

  // A zero timeout would split before the read strobe even left the port.
  if (SPLIT_TIMEOUT == 0) begin : g_bad_timeout
    $error("slave_port_ctrl: SPLIT_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WRITE = 3'd3,
    RREQ  = 3'd4,
    RWAIT = 3'd5,
    SPLIT = 3'd6,
    RDATA = 3'd7
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  mode_q;
  logic [BC_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0] rd_sr;
  logic                  wr_hs;
  logic                  rd_hs;
  logic                  cnt_last;

  assign wr_hs    = bus.master_valid & bus.slave_ready;
  assign rd_hs    = bus.slave_valid & bus.master_ready;
  assign cnt_last = (bit_cnt == '0);

`ifdef SLAVE_SPLIT_EN
  localparam int unsigned WC_W = $clog2(SPLIT_TIMEOUT + 1);
  logic [WC_W-1:0] wait_cnt;
  logic            wait_expire;
  // The split is taken in the cycle the counter steps onto SPLIT_TIMEOUT.
  assign wait_expire = ((wait_cnt + WC_W'(1)) == WC_W'(SPLIT_TIMEOUT));
`endif

  // State register
  always_ff @(posedge clk or negedge rstn) begin : p_state
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode
  always_comb begin : p_next
    next_state = state;
    case (state)
      IDLE:  if (wr_hs) next_state = ADDR;
      ADDR:  if (wr_hs && cnt_last) next_state = mode_q ? WDATA : RREQ;
      WDATA: if (wr_hs && cnt_last) next_state = WRITE;
      WRITE: next_state = IDLE;
      RREQ:  next_state = RWAIT;
      RWAIT: begin
        if (bus.mem_rvalid) next_state = RDATA;
`ifdef SLAVE_SPLIT_EN
        else if (wait_expire) next_state = SPLIT;
`endif
      end
      SPLIT: begin
`ifdef SLAVE_SPLIT_EN
        if (bus.mem_rvalid) next_state = RDATA;
`else
        next_state = IDLE;
`endif
      end
      RDATA: if (rd_hs && cnt_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode; slave_split drops combinationally with mem_rvalid
  always_comb begin : p_outputs
    bus.slave_ready = 1'b0;
    bus.slave_valid = 1'b0;
    bus.rd_bus      = 1'b0;
    bus.slave_split = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_re      = 1'b0;
    case (state)
      IDLE, ADDR, WDATA: bus.slave_ready = 1'b1;
      WRITE: bus.mem_we = 1'b1;
      RREQ:  bus.mem_re = 1'b1;
      SPLIT: begin
`ifdef SLAVE_SPLIT_EN
        bus.slave_split = ~bus.mem_rvalid;
`endif
      end
      RDATA: begin
        bus.slave_valid = 1'b1;
        bus.rd_bus      = rd_sr[DATA_WIDTH-1];
      end
      default: ;
    endcase
  end

  // Shift registers, bit counter and read-wait counter
  always_ff @(posedge clk or negedge rstn) begin : p_datapath
    if (!rstn) begin
      mode_q        <= 1'b0;
      bit_cnt       <= '0;
      rd_sr         <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef SLAVE_SPLIT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (wr_hs) begin
            mode_q       <= bus.mode;
            bus.mem_addr <= {bus.mem_addr[ADDR_WIDTH-2:0], bus.wr_bus};
            bit_cnt      <= BC_W'(ADDR_WIDTH - 2);
          end
        end
        ADDR: begin
          if (wr_hs) begin
            bus.mem_addr <= {bus.mem_addr[ADDR_WIDTH-2:0], bus.wr_bus};
            bit_cnt      <= cnt_last ? BC_W'(DATA_WIDTH - 1) : bit_cnt - BC_W'(1);
          end
        end
        WDATA: begin
          if (wr_hs) begin
            bus.mem_wdata <= {bus.mem_wdata[DATA_WIDTH-2:0], bus.wr_bus};
            bit_cnt       <= bit_cnt - BC_W'(1);
          end
        end
        RREQ: begin
`ifdef SLAVE_SPLIT_EN
          wait_cnt <= '0;
`endif
        end
        RWAIT: begin
          if (bus.mem_rvalid) begin
            rd_sr   <= bus.mem_rdata;
            bit_cnt <= BC_W'(DATA_WIDTH - 1);
          end
`ifdef SLAVE_SPLIT_EN
          else if (wait_cnt != WC_W'(SPLIT_TIMEOUT)) begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
`endif
        end
        SPLIT: begin
`ifdef SLAVE_SPLIT_EN
          if (bus.mem_rvalid) begin
            rd_sr   <= bus.mem_rdata;
            bit_cnt <= BC_W'(DATA_WIDTH - 1);
          end
`endif
        end
        RDATA: begin
          if (rd_hs) begin
            rd_sr   <= {rd_sr[DATA_WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - BC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_port_ctrl.sv
// Scoreboard bench for slave_port_ctrl: stimulus tasks push expected memory
// strobes and read bits into exp_q; a negedge monitor pops and compares them.
module tb_slave_port_ctrl;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 4;

  localparam int EV_WR = 0;
  localparam int EV_RE = 1;
  localparam int EV_RB = 2;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
  } ev_t;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   cyc;
  int   first_cyc;
  bit   mr_toggle;
  bit   sv_seen;
  ev_t  exp_q[$];

  slave_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  slave_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_ev(input int kind, input int addr, input int data, input int rel);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind=%0d addr=%0h data=%0h (t=%0t)", kind, addr, data, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        if (kind != EV_RB) chk("mem_addr", addr, e.addr);
        if (kind == EV_WR) chk("mem_wdata", data, e.data);
        if (kind == EV_RB) chk("rd_bus_bit", data, e.data);
        if (e.cyc >= 0) chk("write_cycle", rel, e.cyc);
      end
    end
  endtask

  // Monitor: one pop per DUT output event
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.slave_valid) sv_seen = 1'b1;
        if (bus.mem_we) check_ev(EV_WR, int'(bus.mem_addr), int'(bus.mem_wdata), cyc - first_cyc);
        if (bus.mem_re) check_ev(EV_RE, int'(bus.mem_addr), 0, 0);
        if (bus.slave_valid && bus.master_ready) check_ev(EV_RB, 0, int'(bus.rd_bus), 0);
      end
    end
  end

  // master_ready driver, changed just after the rising edge
  initial begin
    bus.master_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.master_ready = mr_toggle ? ~bus.master_ready : 1'b1;
    end
  end

  task automatic send_bit(input logic b, input logic m, input bit first);
    int t;
    t = 0;
    @(negedge clk);
    bus.mode         = m;
    bus.wr_bus       = b;
    bus.master_valid = 1'b1;
    while (!bus.slave_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_bit_timeout: slave_ready low for %0d cycles", t);
    end
    if (first) first_cyc = cyc;
    @(posedge clk);
  endtask

  // Mode is only valid with the first bit; later bits carry the inverse.
  task automatic send_word(input int value, input int n, input logic m, input bit gap, input bit is_addr);
    for (int i = n - 1; i >= 0; i--) begin
      if (gap && i != n - 1) begin
        @(negedge clk);
        bus.master_valid = 1'b0;
      end
      send_bit(value[i], (is_addr && i == n - 1) ? m : ~m, is_addr && i == n - 1);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic do_write(input int addr, input int data, input bit gap, input int exp_cyc);
    exp_q.push_back('{EV_WR, addr, data, exp_cyc});
    send_word(addr, AW, 1'b1, gap, 1'b1);
    send_word(data, DW, 1'b1, gap, 1'b0);
    @(negedge clk);
    bus.master_valid = 1'b0;
    wait_drain("write_drain");
  endtask

  task automatic do_read(input int addr, input int data, input int lat);
    int t;
    int first_split;
    bit ready_seen;
    bit split_at_rv;
    logic [DW-1:0] d;
    d = DW'(data);
    first_split = -1;
    ready_seen  = 1'b0;
    split_at_rv = 1'b0;
    exp_q.push_back('{EV_RE, addr, 0, -1});
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back('{EV_RB, 0, int'(d[i]), -1});
    send_word(addr, AW, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.master_valid = 1'b0;
    t = 0;
    while (!bus.mem_re && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("mem_re_seen", int'(bus.mem_re), 1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == lat) begin
        bus.mem_rdata  = d;
        bus.mem_rvalid = 1'b1;
      end
      #1;
      if (bus.slave_ready) ready_seen = 1'b1;
      if (bus.slave_split && first_split < 0) first_split = k;
      if (k == lat) split_at_rv = bus.slave_split;
    end
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    chk("ready_during_wait", int'(ready_seen), 0);
    chk("split_on_rvalid", int'(split_at_rv), 0);
`ifdef SLAVE_SPLIT_EN
    chk("split_rise_cycle", first_split, (lat > TO + 1) ? TO + 1 : -1);
`else
    chk("split_never", first_split, -1);
`endif
    wait_drain("read_drain");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    first_cyc = 0;
    mr_toggle = 1'b0;
    sv_seen = 1'b0;
    rstn = 1'b0;
    bus.mode = 1'b0;
    bus.wr_bus = 1'b0;
    bus.master_valid = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_rvalid = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_slave_ready", int'(bus.slave_ready), 1);
    chk("rst_slave_valid", int'(bus.slave_valid), 0);
    chk("rst_rd_bus", int'(bus.rd_bus), 0);
    chk("rst_slave_split", int'(bus.slave_split), 0);
    chk("rst_mem_we_re", int'({bus.mem_we, bus.mem_re}), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Continuous write: strobe lands 20 cycles after the first bit
    do_write(32'hA5C, 32'h3E, 1'b0, 20);
    repeat (3) @(negedge clk);
    chk("hold_mem_addr", int'(bus.mem_addr), 32'hA5C);
    chk("hold_mem_wdata", int'(bus.mem_wdata), 32'h3E);
    chk("idle_ready", int'(bus.slave_ready), 1);

    // Reads: short latency, boundary latency at the timeout, long latency
    do_read(32'h001, 32'h96, 2);
    do_read(32'h7F3, 32'hA1, TO);
    do_read(32'h7F3, 32'h5A, 10);

    // Stalled handshakes on both sides
    do_write(32'h3C1, 32'hC7, 1'b1, -1);
    mr_toggle = 1'b1;
    do_read(32'h800, 32'h69, 3);
    mr_toggle = 1'b0;

    // Stray mem_rvalid while idle is ignored
    sv_seen = 1'b0;
    @(negedge clk);
    bus.mem_rdata = 8'hFF;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_rvalid_ignored", int'(sv_seen), 0);

    // Reset while waiting for read data; late response is dropped
    exp_q.push_back('{EV_RE, 32'h123, 0, -1});
    send_word(32'h123, AW, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.master_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_slave_ready", int'(bus.slave_ready), 1);
    chk("midrst_mem_addr", int'(bus.mem_addr), 0);
    chk("midrst_outputs", int'({bus.slave_valid, bus.slave_split, bus.mem_re, bus.mem_we}), 0);
    @(negedge clk);
    rstn = 1'b1;
    sv_seen = 1'b0;
    @(negedge clk);
    bus.mem_rdata = 8'h77;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_valid", int'(sv_seen), 0);
    chk("midrst_idle", int'(bus.slave_ready), 1);

    // Recovery with all-ones address
    do_write(32'hFFF, 32'h00, 1'b0, 20);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
